skewed_sync_chain: RTL and testbench

- Parametrised multi-stream correlation shaper for unipolar stochastic bitstreams, CH streams ordered by value: in[CH-1] is largest.
- Each lower stream k is re-timed against the already-shaped stream above it, out[k+1], using a per-stage saturating bit-bank counter.
- Two selectable correlation targets:
  - Skewed mode: out[k] ones nest inside out[k+1] ones, for division/min.
  - Anti mode: out[k] ones avoid out[k+1] ones, for subtraction/saturating add.
- Sits between RNG/comparator stream generators and the stochastic arithmetic units.

---
 rtl/skewed_sync_chain.sv | 113 +++++++++++
 tb/tb_skewed_sync_chain.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/skewed_sync_chain.sv
// Correlation shaper for unipolar stochastic bitstreams: each lower stream is
// re-timed against the already-shaped stream above it through a saturating bit bank.
module skewed_sync_chain #(
    parameter int CH    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          mode,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-2:0] drop,
    output logic [CH-2:0] cnt_nz
);

    localparam logic [DEPTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             bit_out;
        logic             dropped;
        logic [DEPTH-1:0] cnt;
    } step_t;

    logic [CH-2:0][DEPTH-1:0] cnt;
    logic [CH-2:0][DEPTH-1:0] cnt_nxt;
    logic                     mode_q;
    logic                     flush;
    logic                     normal;

    // Bank a bit (emit 0); a full bank discards the bit instead of wrapping.
    function automatic step_t bank_store(input logic [DEPTH-1:0] c);
        step_t s;
        s.bit_out = 1'b0;
        s.dropped = (c == CNT_MAX);
        s.cnt     = s.dropped ? c : c + DEPTH'(1);
        return s;
    endfunction

    function automatic step_t bank_release(input logic [DEPTH-1:0] c);
        step_t s;
        s.bit_out = (c != '0);
        s.dropped = 1'b0;
        s.cnt     = s.bit_out ? c - DEPTH'(1) : c;
        return s;
    endfunction

    function automatic step_t bank_pass(input logic b, input logic [DEPTH-1:0] c);
        step_t s;
        s.bit_out = b;
        s.dropped = 1'b0;
        s.cnt     = c;
        return s;
    endfunction

    // One shaping stage: r is the shaped stream above, x the raw stream of this stage.
    function automatic step_t stage_step(input logic anti, input logic r, input logic x,
                                         input logic [DEPTH-1:0] c);
        step_t s;
        case ({anti, r, x})
            3'b011:  s = bank_pass(1'b1, c);
            3'b010:  s = bank_release(c);
            3'b001:  s = bank_store(c);
            3'b000:  s = bank_pass(1'b0, c);
            3'b111:  s = bank_store(c);
            3'b100:  s = bank_release(c);
            3'b110:  s = bank_pass(1'b0, c);
            3'b101:  s = bank_pass(1'b1, c);
            default: s = bank_pass(x, c);
        endcase
        return s;
    endfunction

    always_comb begin
        step_t st;
        st      = '0;
        out     = in;
        drop    = '0;
        cnt_nxt = cnt;
        flush   = clr || (mode != mode_q);
        normal  = rst_n && !flush && en;
        if (flush) begin
            cnt_nxt = '0;
        end else if (normal) begin
            // Top-down so each stage sees the final shaped bit of the stage above.
            for (int k = CH - 2; k >= 0; k--) begin
                st         = stage_step(mode_q, out[k+1], in[k], cnt[k]);
                out[k]     = st.bit_out;
                drop[k]    = st.dropped;
                cnt_nxt[k] = st.cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            mode_q <= mode;
        end
    end

    always_comb begin
        cnt_nz = '0;
        for (int k = 0; k < CH - 1; k++) begin
            cnt_nz[k] = |cnt[k];
        end
    end

endmodule

// File: tb/tb_skewed_sync_chain.sv
// Bench for skewed_sync_chain: a CH=2/DEPTH=2 and a CH=3/DEPTH=4 instance share control.
module tb_skewed_sync_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       mode;
    logic [1:0] in2;
    logic [1:0] out2;
    logic [0:0] drop2;
    logic [0:0] nz2;
    logic [2:0] in3;
    logic [2:0] out3;
    logic [1:0] drop3;
    logic [1:0] nz3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skewed_sync_chain #(.CH(2), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .in(in2), .out(out2), .drop(drop2), .cnt_nz(nz2)
    );

    skewed_sync_chain #(.CH(3), .DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .in(in3), .out(out3), .drop(drop3), .cnt_nz(nz3)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic       mode;
        logic [1:0] in;
        logic [1:0] eo;
        logic       ed;
        logic       enz;
    } vec_t;

    typedef struct {
        string      nm;
        logic       sel3;
        logic [2:0] eo;
        logic [1:0] ed;
        logic [1:0] enz;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic e, input logic c, input logic m, input logic [1:0] i,
                                input logic [1:0] o, input logic d, input logic z);
        vec_t v;
        v.en = e; v.clr = c; v.mode = m; v.in = i; v.eo = o; v.ed = d; v.enz = z;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drive one cycle at negedge, check combinational outputs, then post-edge cnt_nz.
    task automatic do_cycle(input string nm, input logic e, input logic c, input logic m,
                            input logic [1:0] i2, input logic [2:0] i3, input logic sel3,
                            input logic [2:0] eo, input logic [1:0] ed, input logic [1:0] enz,
                            input logic rel);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; mode = m; in2 = i2; in3 = i3;
        if (rel) rst_n = 1'b1;
        x.nm = nm; x.sel3 = sel3; x.eo = eo; x.ed = ed; x.enz = enz;
        sb.push_back(x);
        #2;
        x = sb.pop_front();
        if (x.sel3) begin
            chk({x.nm, " out3"}, 32'(out3), 32'(x.eo));
            chk({x.nm, " drop3"}, 32'(drop3), 32'(x.ed));
        end else begin
            chk({x.nm, " out2"}, 32'(out2), 32'(x.eo[1:0]));
            chk({x.nm, " drop2"}, 32'(drop2), 32'(x.ed[0]));
        end
        @(posedge clk);
        #1;
        if (x.sel3) chk({x.nm, " nz3"}, 32'(nz3), 32'(x.enz));
        else        chk({x.nm, " nz2"}, 32'(nz2), 32'(x.enz[0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; mode = 1'b0;
        in2 = 2'b01; in3 = 3'b001;
        #3;
        chk("rst out2", 32'(out2), 32'h1);
        chk("rst drop2", 32'(drop2), 32'h0);
        chk("rst nz2", 32'(nz2), 32'h0);
        chk("rst out3", 32'(out3), 32'h1);
        chk("rst nz3", 32'(nz3), 32'h0);
        repeat (2) @(posedge clk);

        do_cycle("rel0", 1, 0, 0, 2'b10, 3'b000, 0, 3'b010, 2'b00, 2'b00, 1);

        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b11, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 1, 1));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b11, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b11, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b10, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b00, 2'b01, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2'b01, 2'b01, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b01, 2'b01, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b01, 2'b00, 0, 1));
        tbl.push_back(mk(1, 1, 0, 2'b10, 2'b10, 0, 0));
        tbl.push_back(mk(1, 0, 0, 2'b10, 2'b10, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b10, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b10, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b10, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b11, 2'b10, 1, 1));
        tbl.push_back(mk(1, 0, 1, 2'b01, 2'b01, 0, 1));
        tbl.push_back(mk(1, 0, 1, 2'b10, 2'b10, 0, 1));
        tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle($sformatf("tbl%0d", i), tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].in,
                     3'b000, 0, {1'b0, tbl[i].eo}, {1'b0, tbl[i].ed}, {1'b0, tbl[i].enz}, 0);
        end

        // Three-stream chain: stage 0 banks a bit, then releases it under the shaped stream.
        do_cycle("ch3a", 1, 0, 0, 2'b00, 3'b001, 1, 3'b000, 2'b00, 2'b01, 0);
        do_cycle("ch3b", 1, 0, 0, 2'b00, 3'b100, 1, 3'b100, 2'b00, 2'b01, 0);
        do_cycle("ch3c", 1, 0, 0, 2'b00, 3'b110, 1, 3'b111, 2'b00, 2'b00, 0);
        do_cycle("ch3d", 1, 0, 0, 2'b00, 3'b010, 1, 3'b000, 2'b00, 2'b10, 0);
        do_cycle("ch3e", 1, 0, 0, 2'b00, 3'b100, 1, 3'b110, 2'b00, 2'b00, 0);

        // Random skewed then anti traffic: check the correlation invariants.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                en = 1'b1; clr = 1'b0; mode = m[0];
                in2 = 2'($urandom_range(0, 3));
                in3 = 3'($urandom_range(0, 7));
                #2;
                chk("rnd top2", 32'(out2[1]), 32'(in2[1]));
                chk("rnd top3", 32'(out3[2]), 32'(in3[2]));
                if (i == 0 && m == 1) begin
                    chk("rnd flush2", 32'(out2), 32'(in2));
                    chk("rnd flush3", 32'(out3), 32'(in3));
                end else if (m == 0) begin
                    chk("rnd skew2", 32'(out2[0] & ~out2[1]), 32'h0);
                    chk("rnd skew3", 32'(out3[1:0] & ~out3[2:1]), 32'h0);
                end else begin
                    chk("rnd anti2", 32'(out2[0] & out2[1]), 32'h0);
                    chk("rnd anti3", 32'(out3[1:0] & out3[2:1]), 32'h0);
                end
            end
        end

        // Async reset mid-cycle with a full bank.
        do_cycle("rf0", 1, 0, 0, 2'b00, 3'b000, 0, 3'b000, 2'b00, 2'b00, 0);
        do_cycle("rf1", 1, 0, 0, 2'b01, 3'b000, 0, 3'b000, 2'b00, 2'b01, 0);
        do_cycle("rf2", 1, 0, 0, 2'b01, 3'b000, 0, 3'b000, 2'b00, 2'b01, 0);
        do_cycle("rf3", 1, 0, 0, 2'b01, 3'b000, 0, 3'b000, 2'b00, 2'b01, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst nz2", 32'(nz2), 32'h0);
        chk("arst out2", 32'(out2), 32'h1);
        chk("arst drop2", 32'(drop2), 32'h0);
        mode = 1'b1;
        repeat (2) @(posedge clk);
        do_cycle("rel1", 1, 0, 1, 2'b01, 3'b000, 0, 3'b001, 2'b00, 2'b00, 1);
        do_cycle("rel1b", 1, 0, 1, 2'b11, 3'b000, 0, 3'b010, 2'b00, 2'b01, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst2 nz2", 32'(nz2), 32'h0);
        mode = 1'b0;
        repeat (2) @(posedge clk);
        do_cycle("rel2", 1, 0, 0, 2'b10, 3'b000, 0, 3'b010, 2'b00, 2'b00, 1);

        if (sb.size() != 0) chk("sb empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
